// File: rtl/conv_window_if.sv
// Pixel-stream in / 5x5-window out bundle for the conv window buffer.
// The master drives pixels and the slave (the buffer) returns windows.
interface conv_window_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    logic                  pix_valid;
    logic [DATA_W-1:0]     pix_in;
    logic                  win_valid;
    logic [25*DATA_W-1:0]  win_out;
    logic [ROW_W-1:0]      win_row;
    logic [COL_W-1:0]      win_col;
    logic                  frame_done;

    modport master (
        output pix_valid, pix_in,
        input  win_valid, win_out, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_valid, pix_in,
        output win_valid, win_out, win_row, win_col, frame_done
    );
endinterface

// File: rtl/conv_window_buffer.sv
// Streaming 5x5 sliding-window generator: four line buffers plus a 5x5 window
// register, emitting one window per valid (unpadded, stride-1) position.
module conv_window_buffer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    conv_window_if.slave bus
);
    localparam int TAPS  = 25;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int WIN_W = TAPS * DATA_W;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(3);
    localparam logic [COL_W-1:0] COL_EDGE      = COL_W'(4);
    localparam logic [ROW_W-1:0] ROW_EDGE      = ROW_W'(4);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_r;
    logic [COL_W-1:0]    col_r;
    logic [ROW_W-1:0]    row_r;
    logic [DATA_W-1:0]   lb0_r [IMG_W];
    logic [DATA_W-1:0]   lb1_r [IMG_W];
    logic [DATA_W-1:0]   lb2_r [IMG_W];
    logic [DATA_W-1:0]   lb3_r [IMG_W];
    logic [WIN_W-1:0]    win_r;
    logic [WIN_W-1:0]    win_next_s;
    logic [DATA_W-1:0]   new_col_s [5];
    logic                win_valid_r;
    logic                frame_done_r;
    logic [ROW_W-1:0]    win_row_r;
    logic [COL_W-1:0]    win_col_r;
    logic                col_last_s;
    logic                row_last_s;
    logic                emit_s;

    // Next window: shift every row one column left, append the new column (lb3 on top).
    always_comb begin
        new_col_s[0] = lb3_r[col_r];
        new_col_s[1] = lb2_r[col_r];
        new_col_s[2] = lb1_r[col_r];
        new_col_s[3] = lb0_r[col_r];
        new_col_s[4] = bus.pix_in;
        win_next_s   = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_next_s[(r*5+c)*DATA_W +: DATA_W] = win_r[(r*5+c+1)*DATA_W +: DATA_W];
            end
            win_next_s[(r*5+4)*DATA_W +: DATA_W] = new_col_s[r];
        end
        col_last_s = (col_r == COL_LAST);
        row_last_s = (row_r == ROW_LAST);
        // Columns 0..3 only refill the left edge, so no window straddles two rows.
        emit_s     = (state_r == STREAM) && (col_r >= COL_EDGE);
    end

    // Raster counters, FILL/STREAM control, line buffers, window and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FILL;
            col_r        <= '0;
            row_r        <= '0;
            win_r        <= '0;
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            win_row_r    <= '0;
            win_col_r    <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0_r[i] <= '0;
                lb1_r[i] <= '0;
                lb2_r[i] <= '0;
                lb3_r[i] <= '0;
            end
        end else begin
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            if (bus.pix_valid) begin
                win_r        <= win_next_s;
                lb3_r[col_r] <= lb2_r[col_r];
                lb2_r[col_r] <= lb1_r[col_r];
                lb1_r[col_r] <= lb0_r[col_r];
                lb0_r[col_r] <= bus.pix_in;
                win_valid_r  <= emit_s;
                frame_done_r <= emit_s && row_last_s && col_last_s;
                if (emit_s) begin
                    win_row_r <= row_r - ROW_EDGE;
                    win_col_r <= col_r - COL_EDGE;
                end
                if (col_last_s) begin
                    col_r <= '0;
                    row_r <= row_last_s ? '0 : row_r + ROW_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
                case (state_r)
                    FILL: begin
                        if (col_last_s && (row_r == ROW_FILL_LAST)) begin
                            state_r <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (col_last_s && row_last_s) begin
                            state_r <= FILL;
                        end
                    end
                    default: state_r <= FILL;
                endcase
            end
        end
    end

    assign bus.win_valid  = win_valid_r;
    assign bus.win_out    = win_r;
    assign bus.win_row    = win_row_r;
    assign bus.win_col    = win_col_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer: expected windows are queued as pixels
// are driven and popped when the DUT raises win_valid.
module tb_conv_window_buffer;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int DW = 8;

    typedef struct {
        logic [25*DW-1:0] win;
        logic [4:0]       row;
        logic [4:0]       col;
        logic             fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    conv_window_if #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) bus ();
    conv_window_if #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) sbus ();

    conv_window_buffer #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_window_buffer #(.IMG_W(5), .IMG_H(5), .DATA_W(DW)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    function automatic logic [7:0] pix_at(input int r, input int c, input int off);
        return 8'((32 * r + c + off) & 255);
    endfunction

    function automatic logic [25*DW-1:0] exp_win(input int r, input int c, input int off);
        logic [25*DW-1:0] w;
        w = '0;
        for (int k = 0; k < 25; k++) begin
            w[8*k +: 8] = pix_at(r - 4 + k / 5, c - 4 + k % 5, off);
        end
        return w;
    endfunction

    task automatic step(input logic v, input logic [7:0] p);
        bus.pix_valid = v;
        bus.pix_in    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int off, input bit toggle, input int abort_at,
                             output int pulses, output int fds, output int first_idx,
                             output logic [25*DW-1:0] first_win, output logic [25*DW-1:0] last_win);
        exp_t             e;
        logic             expv;
        logic [25*DW-1:0] held;
        pulses    = 0;
        fds       = 0;
        first_idx = -1;
        first_win = '0;
        last_win  = '0;
        for (int n = 0; n < W * H; n++) begin
            int r;
            int c;
            r = n / W;
            c = n % W;
            if (n == abort_at) begin
                rst = 1'b1;
                step(1'b1, pix_at(r, c, off));
                rst = 1'b0;
                checks++;
                if (bus.win_valid !== 1'b0 || bus.win_out !== '0) begin
                    errors++;
                    $display("FAIL post_reset: win_valid=%b win_out=%h want 0/0", bus.win_valid, bus.win_out);
                end
                exp_q.delete();
                return;
            end
            expv = (r >= 4 && c >= 4) ? 1'b1 : 1'b0;
            if (expv) begin
                e.win = exp_win(r, c, off);
                e.row = 5'(r - 4);
                e.col = 5'(c - 4);
                e.fd  = (r == H - 1 && c == W - 1) ? 1'b1 : 1'b0;
                exp_q.push_back(e);
            end
            step(1'b1, pix_at(r, c, off));
            checks++;
            if (bus.win_valid !== expv) begin
                errors++;
                $display("FAIL win_valid pix(%0d,%0d): got %b want %b", r, c, bus.win_valid, expv);
            end
            if (bus.win_valid === 1'b1) begin
                pulses++;
                if (first_idx < 0) begin
                    first_idx = n;
                    first_win = bus.win_out;
                end
                last_win = bus.win_out;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_window pix(%0d,%0d): got window, want none", r, c);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.win_out !== e.win || bus.win_row !== e.row ||
                        bus.win_col !== e.col || bus.frame_done !== e.fd) begin
                        errors++;
                        $display("FAIL window pix(%0d,%0d): got %h r%0d c%0d fd%b want %h r%0d c%0d fd%b",
                                 r, c, bus.win_out, bus.win_row, bus.win_col, bus.frame_done,
                                 e.win, e.row, e.col, e.fd);
                    end
                end
            end else begin
                checks++;
                if (bus.frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_frame_done pix(%0d,%0d): got %b want 0", r, c, bus.frame_done);
                end
            end
            if (bus.frame_done === 1'b1) fds++;
            if (toggle) begin
                held = bus.win_out;
                step(1'b0, 8'hA5);
                checks++;
                if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.win_out !== held) begin
                    errors++;
                    $display("FAIL idle_hold pix(%0d,%0d): valid=%b fd=%b win changed=%b want 0/0/0",
                             r, c, bus.win_valid, bus.frame_done, (bus.win_out !== held));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 8'h00);
        step(1'b1, 8'h5A);
        checks++;
        if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b fd=%b want 0/0", bus.win_valid, bus.frame_done);
        end
        checks++;
        if (bus.win_out !== '0 || bus.win_row !== 5'd0 || bus.win_col !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: win=%h row=%0d col=%0d want 0", bus.win_out, bus.win_row, bus.win_col);
        end
        checks++;
        if (sbus.win_valid !== 1'b0 || sbus.win_out !== '0) begin
            errors++;
            $display("FAIL reset_small: valid=%b win=%h want 0/0", sbus.win_valid, sbus.win_out);
        end
        rst = 1'b0;
        bus.pix_valid = 1'b0;
    endtask

    task automatic check_ramp_frame(input string tag, input int pulses, input int fds, input int first_idx,
                                    input logic [25*DW-1:0] fw, input logic [25*DW-1:0] lw);
        checks++;
        if (pulses != 784 || fds != 1 || first_idx != 132) begin
            errors++;
            $display("FAIL %s_counts: pulses=%0d fd=%0d first=%0d want 784/1/132", tag, pulses, fds, first_idx);
        end
        checks++;
        if (fw[7:0] !== 8'd0 || fw[39:32] !== 8'd4 || fw[167:160] !== 8'd128 || fw[199:192] !== 8'd132) begin
            errors++;
            $display("FAIL %s_first_bytes: b0=%0d b4=%0d b20=%0d b24=%0d want 0/4/128/132",
                     tag, fw[7:0], fw[39:32], fw[167:160], fw[199:192]);
        end
        checks++;
        if (lw !== exp_win(31, 31, 0) || lw[199:192] !== 8'd255) begin
            errors++;
            $display("FAIL %s_last_window: got %h b24=%0d want b24=255", tag, lw, lw[199:192]);
        end
    endtask

    task automatic test_ramp();
        int p, f, fi;
        logic [25*DW-1:0] fw, lw;
        run_frame(0, 1'b0, -1, p, f, fi, fw, lw);
        check_ramp_frame("ramp", p, f, fi, fw, lw);
    endtask

    task automatic test_toggle();
        int p, f, fi;
        logic [25*DW-1:0] fw, lw;
        run_frame(0, 1'b1, -1, p, f, fi, fw, lw);
        check_ramp_frame("toggle", p, f, fi, fw, lw);
    endtask

    task automatic test_back_to_back();
        int p1, f1, fi1, p2, f2, fi2;
        logic [25*DW-1:0] fw1, lw1, fw2, lw2;
        run_frame(0, 1'b0, -1, p1, f1, fi1, fw1, lw1);
        run_frame(1, 1'b0, -1, p2, f2, fi2, fw2, lw2);
        checks++;
        if (p1 + p2 != 1568 || f1 + f2 != 2) begin
            errors++;
            $display("FAIL b2b_counts: pulses=%0d fd=%0d want 1568/2", p1 + p2, f1 + f2);
        end
        checks++;
        if (fw2[7:0] !== 8'd1 || fi2 != 132) begin
            errors++;
            $display("FAIL b2b_frame2_first: b0=%0d first=%0d want 1/132", fw2[7:0], fi2);
        end
    endtask

    task automatic test_row_boundary();
        logic expv;
        rst = 1'b1;
        step(1'b0, 8'h00);
        rst = 1'b0;
        for (int n = 0; n <= 5 * W + 4; n++) begin
            int r;
            int c;
            r = n / W;
            c = n % W;
            expv = (r >= 4 && c >= 4) ? 1'b1 : 1'b0;
            step(1'b1, pix_at(r, c, 0));
            checks++;
            if (bus.win_valid !== expv) begin
                errors++;
                $display("FAIL rowb_valid pix(%0d,%0d): got %b want %b", r, c, bus.win_valid, expv);
            end
        end
        checks++;
        if (bus.win_out[7:0] !== 8'd32 || bus.win_row !== 5'd1 || bus.win_col !== 5'd0 ||
            bus.win_out !== exp_win(5, 4, 0)) begin
            errors++;
            $display("FAIL rowb_window: b0=%0d row=%0d col=%0d want 32/1/0", bus.win_out[7:0], bus.win_row, bus.win_col);
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        int p, f, fi;
        logic [25*DW-1:0] fw, lw;
        rst = 1'b1;
        step(1'b0, 8'h00);
        rst = 1'b0;
        run_frame(0, 1'b0, 10 * W + 17, p, f, fi, fw, lw);
        run_frame(0, 1'b0, -1, p, f, fi, fw, lw);
        check_ramp_frame("restart", p, f, fi, fw, lw);
    endtask

    task automatic test_small();
        logic [25*DW-1:0] ew;
        int pulses;
        pulses = 0;
        for (int k = 0; k < 25; k++) ew[8*k +: 8] = 8'(k);
        bus.pix_valid = 1'b0;
        for (int k = 0; k < 26; k++) begin
            sbus.pix_valid = (k < 25) ? 1'b1 : 1'b0;
            sbus.pix_in    = 8'(k);
            @(posedge clk);
            #1;
            if (sbus.win_valid === 1'b1) pulses++;
            checks++;
            if (sbus.win_valid !== (k == 24) || sbus.frame_done !== (k == 24)) begin
                errors++;
                $display("FAIL small_flags k=%0d: valid=%b fd=%b want %b", k, sbus.win_valid, sbus.frame_done, (k == 24));
            end
            if (k == 24) begin
                checks++;
                if (sbus.win_out !== ew || sbus.win_row !== 3'd0 || sbus.win_col !== 3'd0) begin
                    errors++;
                    $display("FAIL small_window: got %h r%0d c%0d want %h r0 c0", sbus.win_out, sbus.win_row, sbus.win_col, ew);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL small_pulses: got %0d want 1", pulses);
        end
        sbus.pix_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.pix_valid  = 1'b0;
        bus.pix_in     = 8'h00;
        sbus.pix_valid = 1'b0;
        sbus.pix_in    = 8'h00;
        test_reset();
        test_ramp();
        test_toggle();
        test_back_to_back();
        test_row_boundary();
        test_mid_reset();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
